// File: rtl/switch_ingress_if.sv
// Host-side packet word stream with a valid/ready handshake.
// The host drives words (master); the switch ingress accepts them (slave).
interface switch_ingress_if #(
  parameter int W_WIDTH = 8
);
  logic [W_WIDTH-1:0] in_data;
  logic               in_valid;
  logic               in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/switch_ingress.sv
// Switch ingress: parses DA/SA/LEN/payload packets and broadcasts words.
// Optional trailing parity word check: define SWITCH_INGRESS_PARITY_EN.
module switch_ingress #(
  parameter int NUM_OF_PORTS = 4,
  parameter int W_WIDTH      = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  switch_ingress_if.slave         host,
  input  logic [NUM_OF_PORTS-1:0] port_rd_in,
  output logic                    sw_en,
  output logic [W_WIDTH-1:0]      port_data,
  output logic [W_WIDTH-1:0]      port_addr,
  output logic [15:0]             pkt_cnt,
`ifdef SWITCH_INGRESS_PARITY_EN
  output logic                    err_parity,
`endif
  output logic                    err_timeout
);

  localparam int IW = $clog2(TIMEOUT + 1);

`ifdef SWITCH_INGRESS_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, SA, LEN, PAYLOAD, PARITY, ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, SA, LEN, PAYLOAD, ABORT
  } state_t;
`endif

  state_t             state;
  state_t             nxt;
  logic [W_WIDTH-1:0] rem;
  logic [IW-1:0]      idle;
  logic               ready;
  logic               accept;
  logic               len_zero;
  logic               last_pay;
  logic               in_pkt;
  logic               timeout_hit;
  logic               pkt_done;
`ifdef SWITCH_INGRESS_PARITY_EN
  logic [W_WIDTH-1:0] par;
`endif

  // rst_n is active-high here: ready is forced low during reset
  assign ready = (&port_rd_in) && (state != ABORT) && !rst_n;
  assign accept = host.in_valid && ready;
  assign host.in_ready = ready;

  assign len_zero = (host.in_data == '0);
  assign last_pay = (rem == {{(W_WIDTH-1){1'b0}}, 1'b1});

`ifdef SWITCH_INGRESS_PARITY_EN
  assign in_pkt = (state == SA) || (state == LEN) ||
                  (state == PAYLOAD) || (state == PARITY);
`else
  assign in_pkt = (state == SA) || (state == LEN) ||
                  (state == PAYLOAD);
`endif

  assign timeout_hit = in_pkt && !accept &&
                       (idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    pkt_done = 1'b0;
    unique case (state)
      IDLE: if (accept) nxt = SA;
      SA:   if (accept) nxt = LEN;
      LEN: begin
        if (accept) begin
          if (len_zero) begin
`ifdef SWITCH_INGRESS_PARITY_EN
            nxt = PARITY;
`else
            nxt      = IDLE;
            pkt_done = 1'b1;
`endif
          end else begin
            nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept && last_pay) begin
`ifdef SWITCH_INGRESS_PARITY_EN
          nxt = PARITY;
`else
          nxt      = IDLE;
          pkt_done = 1'b1;
`endif
        end
      end
`ifdef SWITCH_INGRESS_PARITY_EN
      PARITY: begin
        if (accept) begin
          nxt      = IDLE;
          pkt_done = 1'b1;
        end
      end
`endif
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (timeout_hit) nxt = ABORT;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sw_en       <= 1'b0;
      port_data   <= '0;
      port_addr   <= '0;
      pkt_cnt     <= '0;
      err_timeout <= 1'b0;
      rem         <= '0;
      idle        <= '0;
`ifdef SWITCH_INGRESS_PARITY_EN
      par         <= '0;
      err_parity  <= 1'b0;
`endif
    end else begin
      sw_en       <= accept;
      err_timeout <= timeout_hit;
      if (accept) port_data <= host.in_data;
      if (accept && state == IDLE) port_addr <= host.in_data;
      if (accept && state == LEN)
        rem <= host.in_data;
      else if (accept && state == PAYLOAD)
        rem <= rem - 1'b1;
      if (!in_pkt || accept || timeout_hit) idle <= '0;
      else                                  idle <= idle + 1'b1;
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
`ifdef SWITCH_INGRESS_PARITY_EN
      if (accept)
        par <= (state == IDLE) ? host.in_data
                               : (par ^ host.in_data);
      err_parity <= accept && (state == PARITY) &&
                    (host.in_data != par);
`endif
    end
  end

endmodule

// File: tb/tb_switch_ingress.sv
// Bench for switch_ingress: ready vector table, scoreboard of
// forwarded words, and sequences for stall, timeout and reset.
module tb_switch_ingress;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  port_rd_in = 4'hF;
  logic        sw_en;
  logic [7:0]  port_data;
  logic [7:0]  port_addr;
  logic [15:0] pkt_cnt;
  logic        err_timeout;
`ifdef SWITCH_INGRESS_PARITY_EN
  logic        err_parity;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] acc = 8'h00;

  typedef struct {
    logic [3:0] rd;
    logic       exp_rdy;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  switch_ingress_if #(.W_WIDTH(8)) host();

  switch_ingress #(
    .NUM_OF_PORTS(4),
    .W_WIDTH(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(host.slave),
    .port_rd_in(port_rd_in),
    .sw_en(sw_en),
    .port_data(port_data),
    .port_addr(port_addr),
    .pkt_cnt(pkt_cnt),
`ifdef SWITCH_INGRESS_PARITY_EN
    .err_parity(err_parity),
`endif
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h",
               name, act, exp);
    end
  endtask

  // every accepted word must strobe out on the very next cycle
  always @(negedge clk) begin
    if (sw_en) begin
      if (exp_q.size() == 0)
        chk("spurious sw_en", 32'd1, 32'd0);
      else
        chk("port_data", {24'd0, port_data},
            {24'd0, exp_q.pop_front()});
    end else if (exp_q.size() != 0) begin
      chk("missing sw_en", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] w);
    host.in_data  = w;
    host.in_valid = 1'b1;
    #1;
    chk("in_ready on send", {31'd0, host.in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(w);
    acc = acc ^ w;
    @(negedge clk);
    host.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] da,
                          input logic [7:0] sa,
                          input logic [7:0] len);
    acc = 8'h00;
    send(da);
    send(sa);
    send(len);
  endtask

  task automatic tail();
`ifdef SWITCH_INGRESS_PARITY_EN
    send(acc);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sw_en"}, {31'd0, sw_en}, 32'd0);
    chk({tag, " port_data"}, {24'd0, port_data}, 32'd0);
    chk({tag, " port_addr"}, {24'd0, port_addr}, 32'd0);
    chk({tag, " pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
    chk({tag, " err_timeout"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, " in_ready"}, {31'd0, host.in_ready}, 32'd0);
  endtask

  initial begin
    int hit;
    vecs[0] = '{4'b1111, 1'b1};
    vecs[1] = '{4'b1011, 1'b0};
    vecs[2] = '{4'b0111, 1'b0};
    vecs[3] = '{4'b1110, 1'b0};
    vecs[4] = '{4'b0000, 1'b0};
    vecs[5] = '{4'b1101, 1'b0};
    host.in_valid = 1'b0;
    host.in_data  = 8'h00;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      port_rd_in = vecs[i].rd;
      #1;
      chk("in_ready vec", {31'd0, host.in_ready},
          {31'd0, vecs[i].exp_rdy});
      @(negedge clk);
    end
    port_rd_in = 4'hF;

    send_hdr(8'h02, 8'h05, 8'h03);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    tail();
    chk("pkt1 port_addr", {24'd0, port_addr}, 32'h02);
    chk("pkt1 pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    send_hdr(8'h04, 8'h05, 8'h03);
    send(8'h11);
    port_rd_in    = 4'b1011;
    host.in_data  = 8'h22;
    host.in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("stall in_ready", {31'd0, host.in_ready}, 32'd0);
      @(negedge clk);
      chk("stall sw_en", {31'd0, sw_en}, 32'd0);
    end
    port_rd_in = 4'hF;
    send(8'h22);
    send(8'h33);
    tail();
    chk("stall err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("pkt2 port_addr", {24'd0, port_addr}, 32'h04);
    chk("pkt2 pkt_cnt", {16'd0, pkt_cnt}, 32'd2);

    send_hdr(8'h01, 8'h07, 8'h00);
    tail();
    chk("len0 pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    send_hdr(8'h09, 8'h0A, 8'h00);
    tail();
    chk("next DA port_addr", {24'd0, port_addr}, 32'h09);
    chk("len0 pkt_cnt 2", {16'd0, pkt_cnt}, 32'd4);

    acc = 8'h00;
    send(8'h06);
    send(8'h08);
    hit = 0;
    for (int i = 1; i <= 40 && hit == 0; i++) begin
      @(negedge clk);
      if (err_timeout) hit = i;
    end
    chk("timeout cycle", hit, 32'd16);
    chk("abort in_ready", {31'd0, host.in_ready}, 32'd0);
    @(negedge clk);
    chk("timeout pulse", {31'd0, err_timeout}, 32'd0);
    chk("post abort in_ready", {31'd0, host.in_ready}, 32'd1);
    chk("abort pkt_cnt", {16'd0, pkt_cnt}, 32'd4);
    hit = 0;
    repeat (20) begin
      @(negedge clk);
      if (err_timeout) hit++;
    end
    chk("idle no timeout", hit, 32'd0);
    send_hdr(8'h0C, 8'h01, 8'h00);
    tail();
    chk("after abort DA", {24'd0, port_addr}, 32'h0C);
    chk("after abort pkt_cnt", {16'd0, pkt_cnt}, 32'd5);

    send_hdr(8'h0D, 8'h02, 8'h04);
    send(8'h01);
    send(8'h02);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("mid reset");
    rst_n = 1'b0;
    send_hdr(8'h0E, 8'h03, 8'h01);
    send(8'h5A);
    tail();
    chk("fresh port_addr", {24'd0, port_addr}, 32'h0E);
    chk("fresh pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

`ifdef SWITCH_INGRESS_PARITY_EN
    send_hdr(8'h03, 8'h01, 8'h01);
    send(8'h10);
    send(8'h13);
    chk("parity ok", {31'd0, err_parity}, 32'd0);
    chk("parity ok pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    send_hdr(8'h03, 8'h01, 8'h01);
    send(8'h10);
    send(8'h00);
    chk("parity bad", {31'd0, err_parity}, 32'd1);
    chk("parity bad pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    @(negedge clk);
    chk("parity pulse", {31'd0, err_parity}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_ingress.md
SWITCH_INGRESS -- requirements
Module: switch_ingress

Interface
REQ-001 The block SHALL have parameter NUM_OF_PORTS, default 4, the number of output ports fed in parallel.
REQ-002 The block SHALL have parameter W_WIDTH, default 8, the word width of all data and address buses.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum idle cycles allowed between words of one packet.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-high (1 = reset asserted).
REQ-006 The block SHALL have port in_data, input, W_WIDTH, the host packet word.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-009 The block SHALL have port port_rd_in, input, NUM_OF_PORTS, with bit i high meaning port i FIFO is not full.
REQ-010 The block SHALL have port sw_en, output, 1, a strobe meaning port_data holds a packet word this cycle.
REQ-011 The block SHALL have port port_data, output, W_WIDTH, the word broadcast to all ports.
REQ-012 The block SHALL have port port_addr, output, W_WIDTH, the destination address (DA) of the current packet.
REQ-013 The block SHALL have port pkt_cnt, output, 16, the count of completed packets.
REQ-014 The block SHALL have port err_timeout, output, 1, a one-cycle pulse on packet abort.

Function
REQ-015 Packet format SHALL be: DA, SA, LEN, then LEN payload words; LEN = 0 is legal (header only).
REQ-016 A word SHALL be accepted only in a cycle with in_valid = 1 and in_ready = 1.
REQ-017 in_ready SHALL be combinational: 1 when all bits of port_rd_in are 1 and the state is not ABORT.
REQ-018 An accepted word SHALL appear on port_data with sw_en = 1 exactly one cycle later (1-cycle latency).
REQ-019 sw_en SHALL be 0 in every cycle following a non-accept cycle; port_data SHALL hold its last value then.
REQ-020 port_addr SHALL load DA in the same cycle DA is driven on port_data, and hold it until the next DA.
REQ-021 The FSM SHALL have states IDLE, SA, LEN, PAYLOAD and ABORT.
REQ-022 IDLE to SA SHALL occur on accept; SA to LEN SHALL occur on accept; LEN SHALL latch the remaining-word counter on accept.
REQ-023 From LEN on accept: LEN = 0 SHALL go to IDLE and increment pkt_cnt; otherwise the FSM SHALL go to PAYLOAD.
REQ-024 PAYLOAD SHALL decrement the counter per accept; accept of the last word SHALL go to IDLE and increment pkt_cnt.
REQ-025 The idle counter SHALL count cycles without an accept in SA, LEN and PAYLOAD, and clear on each accept.
REQ-026 The idle counter SHALL count stalls caused by port_rd_in as well as in_valid = 0.
REQ-027 When the idle counter reaches TIMEOUT, the FSM SHALL enter ABORT and pulse err_timeout for 1 cycle.
REQ-028 ABORT SHALL last exactly 1 cycle with in_ready = 0, then go to IDLE; the next word accepted is treated as DA.
REQ-029 pkt_cnt SHALL wrap from 0xFFFF to 0 and SHALL NOT count aborted packets.
REQ-030 In IDLE, the idle counter SHALL be held at 0.

Reset
REQ-031 With rst_n = 1 at a clock edge: the FSM SHALL be IDLE; sw_en, port_data, port_addr, pkt_cnt, err_timeout, and the counters SHALL be 0.
REQ-032 Reset mid-packet SHALL discard the packet with no pulse and no count; in_ready SHALL be 0 while rst_n = 1.

Configuration
REQ-033 Macro SWITCH_INGRESS_PARITY_EN, when defined, SHALL add a PARITY state after the last payload word, or after LEN when LEN = 0.
REQ-034 With the macro, the host SHALL send one trailing word equal to the XOR of all preceding words of the packet.
REQ-035 With the macro, the parity word SHALL be forwarded like any other word.
REQ-036 With the macro, the block SHALL add output err_parity, a 1-cycle pulse concurrent with the sw_en of a mismatching parity word.
REQ-037 With the macro, pkt_cnt SHALL count the packet when it ends in the PARITY state, whether or not parity matched.
REQ-038 Without the macro, the block SHALL have no PARITY state and no err_parity port, and packets SHALL end per REQ-023/REQ-024.

Verification
REQ-039 The bench SHALL check: packet 02,05,03,AA,BB,CC back-to-back, all ports ready -> six sw_en strobes each one cycle after accept; port_addr = 02; pkt_cnt = 1.
REQ-040 The bench SHALL check: port_rd_in = 4'b1011 during the payload -> in_ready = 0 and no sw_en; on release, data resumes intact.
REQ-041 The bench SHALL check: packet 01,07,00 -> three strobes, FSM returns to IDLE, pkt_cnt increments, next word is treated as DA.
REQ-042 The bench SHALL check: in_valid = 0 for 16 cycles after the SA word -> err_timeout pulses once, in_ready = 0 for 1 cycle, pkt_cnt unchanged.
REQ-043 The bench SHALL check: rst_n = 1 in the middle of the PAYLOAD state -> all outputs 0 next cycle, and a fresh packet is forwarded correctly.
REQ-044 The bench SHALL check, with SWITCH_INGRESS_PARITY_EN: packet 03,01,01,10 with parity 13 -> no error; same packet with parity 00 -> err_parity pulses once.
